// File: rtl/sync_fifo_flags.sv
// Single-clock parametrised FIFO with almost-full/almost-empty thresholds, occupancy count
// and sticky overflow/underflow flags. Define FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    // Reject illegal configurations at elaboration rather than misbehaving silently.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of two and at least 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_ok;
    logic rd_ok;

    // Status flags come only from the registered count, so no input reaches them combinationally.
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign fill_count   = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // NOTE: combinational blocks use blocking assignments and default every output first,
    // so no path through the block can leave a signal unassigned and infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (wr_en && full);
        underflow_d = underflow_q | (rd_en && empty);

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear,
    // and leaving it out lets the array map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always presented; rd_en only acknowledges and advances the read pointer.
    assign data_out = mem[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
        data_out_d = data_out_q;
        if (rd_ok) begin
            data_out_d = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed, table-driven bench for sync_fifo_flags (DATA_WIDTH=8, DEPTH=16, AF=14, AE=2),
// plus hand-written sequences for power-on reset, mid-operation reset and the read-path corner.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk;
    logic          clk_en;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    fill_count;
    logic          overflow;
    logic          underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    sync_fifo_flags #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .fill_count  (fill_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Clock stays parked low until the power-on reset check has been made.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit            do_rst;
        bit            wr;
        bit            rd;
        logic [DW-1:0] din;
        int            cnt;
        bit            ovf;
        bit            udf;
        bit            dchk;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit w, bit rd, logic [DW-1:0] d, int cnt,
                                bit ovf, bit udf, bit dchk, logic [DW-1:0] dout);
        vec_t v;
        v.do_rst = r;
        v.wr     = w;
        v.rd     = rd;
        v.din    = d;
        v.cnt    = cnt;
        v.ovf    = ovf;
        v.udf    = udf;
        v.dchk   = dchk;
        v.dout   = dout;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Flags are re-derived from the expected count by the bench's own threshold decode.
    task automatic check_state(input string tag, input int cnt, input bit ovf, input bit udf);
        check({tag, ".fill_count"},   int'(fill_count),   cnt);
        check({tag, ".full"},         int'(full),         int'(cnt == DEPTH));
        check({tag, ".empty"},        int'(empty),        int'(cnt == 0));
        check({tag, ".almost_full"},  int'(almost_full),  int'(cnt >= AF));
        check({tag, ".almost_empty"}, int'(almost_empty), int'(cnt <= AE));
        check({tag, ".overflow"},     int'(overflow),     int'(ovf));
        check({tag, ".underflow"},    int'(underflow),    int'(udf));
    endtask

    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        clk_en  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;

        // Power-on reset with no clock running.
        rst = 1'b1;
        #2;
        check_state("por", 0, 1'b0, 1'b0);
        check("por.data_out", int'(data_out), 0);
        #1;
        rst    = 1'b0;
        clk_en = 1'b1;

        // Fill to full, then a rejected write.
        for (int i = 1; i <= DEPTH; i++) add(0, 1, 0, 8'(i), i, 0, 0, 1, 8'h00);
        add(0, 1, 0, 8'hFF, 16, 1, 0, 1, 8'h00);
        // Drain in order, then a rejected read.
        for (int i = 1; i <= DEPTH; i++) add(0, 0, 1, 8'h00, 16 - i, 1, 0, 1, 8'(i));
        add(0, 0, 1, 8'h00, 0, 1, 1, 1, 8'h10);

        // Simultaneous request while empty: write wins, read rejected.
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);
        add(0, 1, 1, 8'h40, 1, 0, 1, 1, 8'h00);
        add(0, 0, 1, 8'h00, 0, 0, 1, 1, 8'h40);

        // Simultaneous request at fill_count=5: count holds, order preserved.
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'(8'h50 + i), i + 1, 0, 0, 1, 8'h00);
        add(0, 1, 1, 8'h55, 5, 0, 0, 1, 8'h50);
        for (int i = 1; i <= 5; i++) add(0, 0, 1, 8'h00, 5 - i, 0, 0, 1, 8'(8'h50 + i));

        // Simultaneous request while full: read wins, write rejected.
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < DEPTH; i++) add(0, 1, 0, 8'(8'h60 + i), i + 1, 0, 0, 1, 8'h00);
        add(0, 1, 1, 8'hEE, 15, 1, 0, 1, 8'h60);
        for (int i = 1; i < DEPTH; i++) add(0, 0, 1, 8'h00, 15 - i, 1, 0, 1, 8'(8'h60 + i));

        // Three write-10/read-10 rounds so both pointers wrap.
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++)
                add(0, 1, 0, 8'(8'h20 + 10 * r + k), k + 1, 0, 0, 1,
                    (r == 0) ? 8'h00 : 8'(8'h20 + 10 * r - 1));
            for (int k = 0; k < 10; k++)
                add(0, 0, 1, 8'h00, 9 - k, 0, 0, 1, 8'(8'h20 + 10 * r + k));
        end

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            if (vecs[i].do_rst) begin
                @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_state(tag, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
`ifndef FIFO_FWFT_EN
                if (vecs[i].dchk) check({tag, ".data_out"}, int'(data_out), int'(vecs[i].dout));
`endif
                rst = 1'b0;
            end else begin
                step(vecs[i].wr, vecs[i].rd, vecs[i].din);
                check_state(tag, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
`ifndef FIFO_FWFT_EN
                if (vecs[i].dchk) check({tag, ".data_out"}, int'(data_out), int'(vecs[i].dout));
`endif
            end
        end

        // Mid-operation reset: six words in, then a seventh whose request must not
        // reach the status outputs before the edge.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
        @(negedge clk);
        wr_en   = 1'b1;
        data_in = 8'h76;
        #1;
        check("comb.fill_count", int'(fill_count), 6);
        check("comb.empty",      int'(empty),      0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check_state("pre_rst", 7, 1'b0, 1'b0);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_state("mid_rst", 0, 1'b0, 1'b0);
        rst = 1'b0;

        step(1'b1, 1'b0, 8'hA5);
        check_state("post_rst_wr", 1, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        check("fwft.head", int'(data_out), 8'hA5);
        step(1'b0, 1'b1, 8'h00);
        check_state("fwft.pop", 0, 1'b0, 1'b0);
`else
        check("post_rst.data_out_before_rd", int'(data_out), 8'h00);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst.data_out", int'(data_out), 8'hA5);
        check_state("post_rst_rd", 0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
